spi_frame_engine: RTL and testbench

Bit-level SPI master for the ADXL345 accelerometer link. It sits directly downstream of the accelerometer SPI controller and takes one 16-bit command/data word per start/done handshake. It drives CSN, a gated SCLK, and SDI in SPI mode 3, and returns the final received byte from SDO. Runs entirely in the spi_clk domain.

---
 rtl/spi_frame_engine_pkg.sv | 28 ++
 rtl/spi_frame_engine_if.sv | 15 +
 rtl/spi_frame_engine_sclk_gate.sv | 24 ++
 rtl/spi_frame_engine.sv | 123 ++++++++++++
 tb/tb_spi_frame_engine.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_engine_pkg.sv
// rtl/spi_frame_engine_pkg.sv - shared types and constants for the SPI frame engine
package spi_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } frame_state_t;

    // Top two bits of the ADXL345 command byte; the engine never decodes them.
    localparam logic [1:0] SPI_WRITE_MODE = 2'b00;
    localparam logic [1:0] SPI_READ_MODE  = 2'b10;

    localparam int DEF_TX_WIDTH = 16;
    localparam int DEF_RX_WIDTH = 8;

    // Counter width able to hold 0..max(a,b,c)-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/spi_frame_engine_if.sv
// rtl/spi_frame_engine_if.sv - start/done command handshake between controller and frame engine
interface spi_frame_engine_if
    import spi_frame_pkg::*;
#(
    parameter int TX_WIDTH = DEF_TX_WIDTH,
    parameter int RX_WIDTH = DEF_RX_WIDTH
);
    logic                start;
    logic [TX_WIDTH-1:0] data_tx;
    logic                done;
    logic [RX_WIDTH-1:0] data_rx;

    modport master (output start, output data_tx, input done, input data_rx);
    modport slave  (input start, input data_tx, output done, output data_rx);
endinterface

// File: rtl/spi_frame_engine_sclk_gate.sv
// rtl/spi_frame_engine_sclk_gate.sv - registered SCLK enable and OR-gating of spi_clk_out
module spi_sclk_gate (
    input  logic reset,
    input  logic spi_clk,
    input  logic spi_clk_out,
    input  logic sclk_set,
    input  logic sclk_clr,
    output logic sclk
);
    logic sclk_en;

    // Enable changes only just after a posedge spi_clk, where spi_clk_out is high, so SCLK never glitches.
    always_ff @(posedge spi_clk or negedge reset) begin
        if (!reset) begin
            sclk_en <= 1'b0;
        end else if (sclk_clr) begin
            sclk_en <= 1'b0;
        end else if (sclk_set) begin
            sclk_en <= 1'b1;
        end
    end

    assign sclk = spi_clk_out | ~sclk_en;
endmodule

// File: rtl/spi_frame_engine.sv
// rtl/spi_frame_engine.sv - SPI mode-3 frame master for ADXL345; SPI_FRAME_ENGINE_ABORT_EN enables mid-frame abort
module spi_frame_engine
    import spi_frame_pkg::*;
#(
    parameter int TX_WIDTH        = DEF_TX_WIDTH,
    parameter int RX_WIDTH        = DEF_RX_WIDTH,
    parameter int CS_SETUP_CYCLES = 1,
    parameter int CS_HOLD_CYCLES  = 1
) (
    input  logic               reset,
    input  logic               spi_clk,
    input  logic               spi_clk_out,
    spi_frame_engine_if.slave  host,
    output logic               SPI_SDI,
    input  logic               SPI_SDO,
    output logic               SPI_CSN,
    output logic               SPI_CLK
);
    localparam int CNT_W = cnt_width(TX_WIDTH, CS_SETUP_CYCLES, CS_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(TX_WIDTH - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYCLES - 1);

    frame_state_t        state;
    logic [CNT_W-1:0]    cnt;
    logic [TX_WIDTH-1:0] tx_sr;
    logic [RX_WIDTH-1:0] rx_sr;
    logic [RX_WIDTH-1:0] rx_next;
    logic                abort;
    logic                sclk_set;
    logic                sclk_clr;

    // Only the trailing RX_WIDTH bits of the frame are kept.
    assign rx_next = RX_WIDTH'({rx_sr, SPI_SDO});

`ifdef SPI_FRAME_ENGINE_ABORT_EN
    assign abort = !host.start && (state inside {CS_SETUP, SHIFT, CS_HOLD});
`else
    assign abort = 1'b0;
`endif

    assign sclk_set = (state == CS_SETUP) && (cnt == SETUP_LAST);
    assign sclk_clr = ((state == SHIFT) && (cnt == SHIFT_LAST)) || abort;

    spi_sclk_gate u_sclk_gate (
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_clk_out (spi_clk_out),
        .sclk_set    (sclk_set),
        .sclk_clr    (sclk_clr),
        .sclk        (SPI_CLK)
    );

    // Frame sequencer: chip select, bit shifting and the start/done handshake.
    always_ff @(posedge spi_clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            host.done    <= 1'b0;
            host.data_rx <= '0;
            SPI_CSN      <= 1'b1;
            SPI_SDI      <= 1'b1;
        end else if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            SPI_CSN <= 1'b1;
            SPI_SDI <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (host.start) begin
                        tx_sr   <= host.data_tx;
                        SPI_SDI <= host.data_tx[TX_WIDTH-1];
                        SPI_CSN <= 1'b0;
                        cnt     <= '0;
                        state   <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    rx_sr   <= rx_next;
                    tx_sr   <= tx_sr << 1;
                    SPI_SDI <= tx_sr[TX_WIDTH-2];
                    if (cnt == SHIFT_LAST) begin
                        host.data_rx <= rx_next;
                        cnt          <= '0;
                        state        <= CS_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        SPI_CSN   <= 1'b1;
                        SPI_SDI   <= 1'b1;
                        host.done <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE first guarantees a held start cannot retrigger.
                    if (!host.start) begin
                        host.done <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_engine.sv
// tb/tb_spi_frame_engine.sv - directed self-checking bench for spi_frame_engine
module tb_spi_frame_engine;
    import spi_frame_pkg::*;

    logic reset;
    logic spi_clk;
    logic spi_clk_out;
    logic SPI_SDI;
    logic SPI_SDO = 1'b1;
    logic SPI_CSN;
    logic SPI_CLK;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int rises = 0;
    int csn_low = 0;
    int e0 = 0;
    int rises0 = 0;
    int csn0 = 0;
    int n = 0;
    logic        saw_done = 1'b0;
    logic [15:0] slave_rx = '0;
    logic [15:0] slave_tx = '0;
    logic [15:0] slave_data = '0;

    spi_frame_engine_if #(.TX_WIDTH(16), .RX_WIDTH(8)) host ();

    spi_frame_engine #(
        .TX_WIDTH(16), .RX_WIDTH(8), .CS_SETUP_CYCLES(1), .CS_HOLD_CYCLES(1)
    ) dut (
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_clk_out (spi_clk_out),
        .host        (host.slave),
        .SPI_SDI     (SPI_SDI),
        .SPI_SDO     (SPI_SDO),
        .SPI_CSN     (SPI_CSN),
        .SPI_CLK     (SPI_CLK)
    );

    // spi_clk period 10, spi_clk_out lags by 7 so it is high at every posedge spi_clk
    initial begin
        spi_clk = 1'b0;
        spi_clk_out = 1'b0;
        forever begin
            #2 spi_clk_out = 1'b1;
            #3 spi_clk = 1'b1;
            #2 spi_clk_out = 1'b0;
            #3 spi_clk = 1'b0;
        end
    end

    always @(posedge spi_clk) begin
        edge_no++;
        if (SPI_CSN === 1'b0) csn_low++;
    end

    always @(posedge SPI_CLK) begin
        rises++;
        slave_rx = {slave_rx[14:0], SPI_SDI};
    end

    always @(negedge SPI_CSN or negedge SPI_CLK) begin
        if (SPI_CLK) begin
            slave_tx = slave_data;
        end else begin
            SPI_SDO  = slave_tx[15];
            slave_tx = {slave_tx[14:0], 1'b0};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_frame(input logic [15:0] data, input logic [15:0] sdo);
        @(negedge spi_clk);
        rises0       = rises;
        csn0         = csn_low;
        slave_data   = sdo;
        host.data_tx = data;
        host.start   = 1'b1;
        @(posedge spi_clk);
        #1;
        e0 = edge_no;
    endtask

    task automatic wait_done(output int edges);
        edges = edge_no - e0;
        while (host.done !== 1'b1 && edges < 40) begin
            @(posedge spi_clk);
            #1;
            edges = edge_no - e0;
        end
    endtask

    task automatic end_frame();
        host.start = 1'b0;
        @(posedge spi_clk);
        #1;
        check("done_drop", host.done, 1'b0);
        check("csn_between", SPI_CSN, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        host.start = 1'b0;
        host.data_tx = '0;
        repeat (3) @(posedge spi_clk);
        #1;
        check("rst_csn", SPI_CSN, 1'b1);
        check("rst_sclk", SPI_CLK, 1'b1);
        check("rst_sdi", SPI_SDI, 1'b1);
        check("rst_done", host.done, 1'b0);
        check("rst_data_rx", host.data_rx, 8'h00);
        @(negedge spi_clk);
        reset = 1'b1;

        // write frame
        begin_frame({SPI_WRITE_MODE, 6'h24, 8'h20}, 16'h0000);
        wait_done(n);
        check("wr_done_edge", n, 18);
        check("wr_sdi_bits", slave_rx, 16'h2420);
        check("wr_sclk_rises", rises - rises0, 16);
        check("wr_csn_low", csn_low - csn0, 18);
        check("wr_sdi_idle", SPI_SDI, 1'b1);
        end_frame();

        // read frame, then controller restarts after one low edge
        begin_frame({SPI_READ_MODE, 6'h32, 8'h00}, 16'h00A5);
        wait_done(n);
        check("rd_done_edge", n, 18);
        check("rd_data_rx", host.data_rx, 8'hA5);
        end_frame();

        // data_tx changes after accept are ignored; data_rx holds through SHIFT
        begin_frame(16'h2D08, 16'h0033);
        repeat (2) @(posedge spi_clk);
        #1;
        host.data_tx = 16'hFFFF;
        repeat (6) @(posedge spi_clk);
        #1;
        check("rx_hold_in_shift", host.data_rx, 8'hA5);
        wait_done(n);
        check("hs_done_edge", n, 18);
        check("tx_latched_bits", slave_rx, 16'h2D08);
        check("hs_data_rx", host.data_rx, 8'h33);
        end_frame();

        // asynchronous reset in SHIFT at bit 7
        begin_frame(16'h1234, 16'h0000);
        repeat (9) @(posedge spi_clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_csn", SPI_CSN, 1'b1);
        check("arst_sclk", SPI_CLK, 1'b1);
        check("arst_sdi", SPI_SDI, 1'b1);
        check("arst_done", host.done, 1'b0);
        check("arst_data_rx", host.data_rx, 8'h00);
        host.start = 1'b0;
        @(negedge spi_clk);
        reset = 1'b1;
        begin_frame(16'hB255, 16'h5AC3);
        wait_done(n);
        check("post_rst_done_edge", n, 18);
        check("post_rst_data_rx", host.data_rx, 8'hC3);
        check("post_rst_sdi_bits", slave_rx, 16'hB255);
        check("post_rst_rises", rises - rises0, 16);
        end_frame();

        // start dropped at SHIFT bit 4
        begin_frame(16'hF00F, 16'h0077);
        repeat (5) @(posedge spi_clk);
        #1;
        host.start = 1'b0;
        @(posedge spi_clk);
        #1;
`ifdef SPI_FRAME_ENGINE_ABORT_EN
        check("abort_csn", SPI_CSN, 1'b1);
        check("abort_sdi", SPI_SDI, 1'b1);
        saw_done = 1'b0;
        repeat (25) begin
            @(posedge spi_clk);
            #1;
            if (host.done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 1'b0);
        check("abort_rises", rises - rises0, 5);
        check("abort_data_rx", host.data_rx, 8'hC3);
`else
        wait_done(n);
        check("drop_done_edge", n, 18);
        check("drop_data_rx", host.data_rx, 8'h77);
        check("drop_sdi_bits", slave_rx, 16'hF00F);
        check("drop_rises", rises - rises0, 16);
        @(posedge spi_clk);
        #1;
        check("drop_done_clear", host.done, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
